// File: rtl/ibex_fp_pkg.sv
// Shared FP write-back types: producer identifiers, write request layout and
// the register-count helper used to size the scoreboard.
package ibex_fp_pkg;

  localparam int unsigned FP_DATA_W = 16;

  typedef enum logic {
    FP_WB_FPU = 1'b0,
    FP_WB_LSU = 1'b1
  } fp_wb_src_e;

  typedef struct packed {
    logic [4:0]           waddr;
    logic [FP_DATA_W-1:0] wdata;
  } fp_wb_req_t;

  function automatic int unsigned FP_NUM_REGS(bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_fp_scoreboard.sv
// Pending-write scoreboard: one busy bit per FP register, the decode hazard
// stall and the combinational protocol-error term for the write-back stage.
module ibex_fp_scoreboard
  import ibex_fp_pkg::*;
#(
  parameter bit RV32E = 1'b0,
  localparam int unsigned NumRegs = FP_NUM_REGS(RV32E)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  input  logic [4:0]         issue_rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [4:0]         rd_i,
  input  logic               rd_used_i,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic               acc_valid_i,
  input  logic [4:0]         acc_addr_i,
  output logic [NumRegs-1:0] busy_o,
  output logic               stall_o,
  output logic               err_o
);

  localparam int unsigned IdxW = RV32E ? 4 : 5;

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busyNext;
  logic               w_accErr;
  logic               w_rangeErr;

  // Under RV32E, addresses with bit 4 set lie outside the register space.
  function automatic logic addrOk(logic [4:0] a);
    return !RV32E || !a[4];
  endfunction

  function automatic logic isBusy(logic [NumRegs-1:0] b, logic [4:0] a);
    return addrOk(a) && b[a[IdxW-1:0]];
  endfunction

  // Clear is applied before set so that an issue landing on the committing
  // register keeps it busy.
  always_comb begin
    w_busyNext = r_busy;
    if (we_i && (waddr_i != 5'd0) && addrOk(waddr_i))
      w_busyNext[waddr_i[IdxW-1:0]] = 1'b0;
    if (issue_valid_i && (issue_rd_i != 5'd0) && addrOk(issue_rd_i))
      w_busyNext[issue_rd_i[IdxW-1:0]] = 1'b1;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_busy <= '0;
    else       r_busy <= w_busyNext;
  end

  always_comb begin
    w_accErr   = acc_valid_i && (acc_addr_i != 5'd0) && addrOk(acc_addr_i)
                 && !isBusy(r_busy, acc_addr_i);
    w_rangeErr = RV32E && ((acc_valid_i && acc_addr_i[4]) ||
                           (issue_valid_i && issue_rd_i[4]));
  end

  assign busy_o  = r_busy;
  assign stall_o = isBusy(r_busy, rs1_i) | isBusy(r_busy, rs2_i) |
                   (rd_used_i & isBusy(r_busy, rd_i));
  assign err_o   = w_accErr | w_rangeErr;

endmodule

// File: rtl/ibex_fp_wb_arbiter.sv
// FP register-file write-back: round-robin arbitration between FPU and LSU,
// a registered write port and the pending-write scoreboard.
module ibex_fp_wb_arbiter
  import ibex_fp_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = FP_DATA_W,
  localparam int unsigned NumRegs  = FP_NUM_REGS(RV32E)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 rd_used_i,
  output logic                 stall_o,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_waddr_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic [4:0]           fp_waddr_a_o,
  output logic [DataWidth-1:0] fp_wdata_a_o,
  output logic                 fp_we_a_o,
  output logic [NumRegs-1:0]   busy_o,
  output logic                 err_o
);

  fp_wb_src_e           r_lastGrant;
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_err;

  logic                 w_tie;
  logic                 w_fpuAcc;
  logic                 w_lsuAcc;
  logic                 w_acc;
  logic [4:0]           w_accAddr;
  logic [DataWidth-1:0] w_accData;
  logic                 w_sbErr;

  // The output stage never back-pressures, so a requester is only held off
  // when it loses a tie.
  assign w_tie       = fpu_valid_i & lsu_valid_i;
  assign fpu_ready_o = !w_tie || (r_lastGrant == FP_WB_LSU);
  assign lsu_ready_o = !w_tie || (r_lastGrant == FP_WB_FPU);

  assign w_fpuAcc  = fpu_valid_i & fpu_ready_o;
  assign w_lsuAcc  = lsu_valid_i & lsu_ready_o;
  assign w_acc     = w_fpuAcc | w_lsuAcc;
  assign w_accAddr = w_fpuAcc ? fpu_waddr_i : lsu_waddr_i;
  assign w_accData = w_fpuAcc ? fpu_wdata_i : lsu_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lastGrant <= FP_WB_LSU;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_we  <= w_acc;
      r_err <= w_sbErr;
      if (w_acc) begin
        r_waddr     <= w_accAddr;
        r_wdata     <= w_accData;
        r_lastGrant <= w_fpuAcc ? FP_WB_FPU : FP_WB_LSU;
      end
    end
  end

  ibex_fp_scoreboard #(
    .RV32E(RV32E)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i   (issue_rd_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rd_i         (rd_i),
    .rd_used_i    (rd_used_i),
    .we_i         (r_we),
    .waddr_i      (r_waddr),
    .acc_valid_i  (w_acc),
    .acc_addr_i   (w_accAddr),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .err_o        (w_sbErr)
  );

  assign fp_we_a_o    = r_we;
  assign fp_waddr_a_o = r_waddr;
  assign fp_wdata_a_o = r_wdata;
  assign err_o        = r_err;

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Directed bench for the FP write-back arbiter; expected register-file writes
// are queued by the stimulus and consumed by an independent write-port monitor.
module tb_ibex_fp_wb_arbiter;
  import ibex_fp_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic          rd_used;
  logic          stall;
  logic          fpu_valid;
  logic          fpu_ready;
  logic [4:0]    fpu_waddr;
  logic [DW-1:0] fpu_wdata;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic [4:0]    fp_waddr;
  logic [DW-1:0] fp_wdata;
  logic          fp_we;
  logic [31:0]   busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  fp_wb_req_t expQ[$];
  fp_wb_req_t monExp;

  always #5 clk = ~clk;

  ibex_fp_wb_arbiter #(
    .RV32E    (1'b0),
    .DataWidth(DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rd_i         (rd),
    .rd_used_i    (rd_used),
    .stall_o      (stall),
    .fpu_valid_i  (fpu_valid),
    .fpu_ready_o  (fpu_ready),
    .fpu_waddr_i  (fpu_waddr),
    .fpu_wdata_i  (fpu_wdata),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_waddr_i  (lsu_waddr),
    .lsu_wdata_i  (lsu_wdata),
    .fp_waddr_a_o (fp_waddr),
    .fp_wdata_a_o (fp_wdata),
    .fp_we_a_o    (fp_we),
    .busy_o       (busy),
    .err_o        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic fv, input logic [4:0] fa, input logic [DW-1:0] fd,
                               input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
    issue_valid = iv;
    issue_rd    = ird;
    fpu_valid   = fv;
    fpu_waddr   = fa;
    fpu_wdata   = fd;
    lsu_valid   = lv;
    lsu_waddr   = la;
    lsu_wdata   = ld;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [DW-1:0] d);
    fp_wb_req_t e;
    e.waddr = a;
    e.wdata = d;
    expQ.push_back(e);
  endtask

  // Write-port monitor: every committed write must match the next queued one.
  always @(negedge clk) begin
    if (fp_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", fp_waddr, fp_wdata);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wb_addr", {27'd0, fp_waddr}, {27'd0, monExp.waddr});
        checkOutput("wb_data", {16'd0, fp_wdata}, {16'd0, monExp.wdata});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; rd_used = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_we", {31'd0, fp_we}, 0);
    checkOutput("rst_waddr", {27'd0, fp_waddr}, 0);
    checkOutput("rst_wdata", {16'd0, fp_wdata}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", {31'd0, err}, 0);
    checkOutput("rst_stall", {31'd0, stall}, 0);

    $display("[TB] tie alternation");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 1, 16'h1111, 1, 2, 16'h2222);
    expectWrite(1, 16'h1111);
    expectWrite(2, 16'h2222);
    checkOutput("tie_busy", busy, 32'h6);
    checkOutput("tie_fpu_ready", {31'd0, fpu_ready}, 1);
    checkOutput("tie_lsu_ready", {31'd0, lsu_ready}, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 16'h2222);
    checkOutput("tie2_lsu_ready", {31'd0, lsu_ready}, 1);
    checkOutput("tie2_we", {31'd0, fp_we}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("tie3_we", {31'd0, fp_we}, 1);
    checkOutput("tie3_err", {31'd0, err}, 0);
    tick();
    checkOutput("tie4_we", {31'd0, fp_we}, 0);
    checkOutput("tie4_busy", busy, 0);

    $display("[TB] single FPU write");
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0);
    tick();
    rs1 = 5'd3;
    applyStimulus(0, 0, 1, 3, 16'h3C00, 0, 0, 0);
    expectWrite(3, 16'h3C00);
    checkOutput("single_fpu_ready", {31'd0, fpu_ready}, 1);
    checkOutput("single_stall", {31'd0, stall}, 1);
    checkOutput("single_busy", busy, 32'h8);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_we", {31'd0, fp_we}, 1);
    checkOutput("single_busy_hold", {31'd0, busy[3]}, 1);
    checkOutput("single_err", {31'd0, err}, 0);
    tick();
    checkOutput("single_busy_clr", busy, 0);
    checkOutput("single_stall_clr", {31'd0, stall}, 0);
    rs1 = 5'd0;

    $display("[TB] RAW stall");
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    tick();
    rs1 = 5'd5;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_stall0", {31'd0, stall}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 16'h5555);
    expectWrite(5, 16'h5555);
    checkOutput("raw_stall1", {31'd0, stall}, 1);
    checkOutput("raw_lsu_ready", {31'd0, lsu_ready}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_we_addr", {26'd0, fp_we, fp_waddr}, {26'd0, 1'b1, 5'd5});
    checkOutput("raw_stall2", {31'd0, stall}, 1);
    tick();
    checkOutput("raw_stall3", {31'd0, stall}, 0);
    rs1 = 5'd0;

    $display("[TB] set/clear collision");
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 7, 16'h7777, 0, 0, 0);
    expectWrite(7, 16'h7777);
    tick();
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("coll_we_addr", {26'd0, fp_we, fp_waddr}, {26'd0, 1'b1, 5'd7});
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("coll_busy7", {31'd0, busy[7]}, 1);
    checkOutput("coll_err", {31'd0, err}, 0);

    $display("[TB] unexpected write");
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 16'h9999);
    expectWrite(9, 16'h9999);
    checkOutput("err_lsu_ready", {31'd0, lsu_ready}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("err_pulse", {31'd0, err}, 1);
    tick();
    checkOutput("err_pulse_end", {31'd0, err}, 0);
    checkOutput("err_busy9", {31'd0, busy[9]}, 0);
    applyStimulus(0, 0, 1, 0, 16'hABCD, 0, 0, 0);
    expectWrite(0, 16'hABCD);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_we", {31'd0, fp_we}, 1);
    checkOutput("r0_err", {31'd0, err}, 0);
    tick();
    checkOutput("r0_err_next", {31'd0, err}, 0);
    checkOutput("r0_busy", busy, 32'h80);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 4, 16'h4444, 0, 0, 0);
    expectWrite(4, 16'h4444);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("mid_we", {31'd0, fp_we}, 1);
    checkOutput("mid_busy", busy, 32'h90);
    tick();
    checkOutput("post_rst_we", {31'd0, fp_we}, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_waddr", {27'd0, fp_waddr}, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 1, 0, 16'h1010, 1, 0, 16'h2020);
    expectWrite(0, 16'h1010);
    expectWrite(0, 16'h2020);
    expectWrite(0, 16'h1010);
    checkOutput("b2b0_fpu_ready", {31'd0, fpu_ready}, 1);
    checkOutput("b2b0_lsu_ready", {31'd0, lsu_ready}, 0);
    tick();
    checkOutput("b2b1_fpu_ready", {31'd0, fpu_ready}, 0);
    checkOutput("b2b1_lsu_ready", {31'd0, lsu_ready}, 1);
    checkOutput("b2b1_we", {31'd0, fp_we}, 1);
    tick();
    checkOutput("b2b2_fpu_ready", {31'd0, fpu_ready}, 1);
    checkOutput("b2b2_lsu_ready", {31'd0, lsu_ready}, 0);
    checkOutput("b2b2_we", {31'd0, fp_we}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b3_we", {31'd0, fp_we}, 1);
    tick();
    checkOutput("b2b4_we", {31'd0, fp_we}, 0);
    checkOutput("b2b4_err", {31'd0, err}, 0);
    tick();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
